// File: rtl/washing_machine.sv
// Washing-machine program sequencer: IDLE -> FILL -> WASH -> RINSE -> SPIN -> DONE -> IDLE.
// Outputs are registered Moore decodes of the state; srt is sampled only in IDLE.
// Macro WASHING_MACHINE_BUZZER_EN: when defined, buzzer follows done; otherwise buzzer is tied low.
module washing_machine #(
    parameter int FILL_CYCLES  = 20,
    parameter int WASH_CYCLES  = 40,
    parameter int RINSE_CYCLES = 30,
    parameter int SPIN_CYCLES  = 30,
    parameter int DONE_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic srt,
    output logic fill,
    output logic wash,
    output logic rinse,
    output logic spin,
    output logic done,
    output logic red,
    output logic green,
    output logic buzzer
);

    localparam int MAX_AB  = (FILL_CYCLES > WASH_CYCLES) ? FILL_CYCLES : WASH_CYCLES;
    localparam int MAX_CD  = (RINSE_CYCLES > SPIN_CYCLES) ? RINSE_CYCLES : SPIN_CYCLES;
    localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_ALL = (MAX_ABC > DONE_CYCLES) ? MAX_ABC : DONE_CYCLES;
    // Guard against a zero-width counter when every phase lasts a single cycle.
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WASH,
        S_RINSE,
        S_SPIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    int            lim;
    logic          last;

    always_comb begin
        lim = 1;
        case (state)
            S_FILL:  lim = FILL_CYCLES;
            S_WASH:  lim = WASH_CYCLES;
            S_RINSE: lim = RINSE_CYCLES;
            S_SPIN:  lim = SPIN_CYCLES;
            S_DONE:  lim = DONE_CYCLES;
            default: lim = 1;
        endcase
    end

    assign last = (cnt == CW'(lim - 1));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (srt)  nxt = S_FILL;
            S_FILL:  if (last) nxt = S_WASH;
            S_WASH:  if (last) nxt = S_RINSE;
            S_RINSE: if (last) nxt = S_SPIN;
            S_SPIN:  if (last) nxt = S_DONE;
            S_DONE:  if (last) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are loaded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            fill  <= 1'b0;
            wash  <= 1'b0;
            rinse <= 1'b0;
            spin  <= 1'b0;
            done  <= 1'b0;
            red   <= 1'b0;
            green <= 1'b1;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || state == S_IDLE) ? '0 : cnt + CW'(1);
            fill  <= (nxt == S_FILL);
            wash  <= (nxt == S_WASH);
            rinse <= (nxt == S_RINSE);
            spin  <= (nxt == S_SPIN);
            done  <= (nxt == S_DONE);
            red   <= (nxt == S_FILL) || (nxt == S_WASH) || (nxt == S_RINSE) || (nxt == S_SPIN);
            green <= (nxt == S_IDLE) || (nxt == S_DONE);
        end
    end

`ifdef WASHING_MACHINE_BUZZER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buzzer <= 1'b0;
        end else begin
            buzzer <= (nxt == S_DONE);
        end
    end
`else
    assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_washing_machine.sv
// Bench for washing_machine: random srt against a timeline model indexed by cycles since start.
module tb_washing_machine;

    localparam int FC    = 20;
    localparam int WC    = 40;
    localparam int RC    = 30;
    localparam int SC    = 30;
    localparam int DC    = 10;
    localparam int TOTAL = FC + WC + RC + SC + DC;
`ifdef WASHING_MACHINE_BUZZER_EN
    localparam bit BZ = 1'b1;
`else
    localparam bit BZ = 1'b0;
`endif
    localparam logic [7:0] IDLE_V = 8'b0000_0010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic srt = 1'b0;
    logic fill, wash, rinse, spin, done, red, green, buzzer;

    int total = 0;
    int bad   = 0;
    int pos   = 0;   // 0 = idle, else cycle number within the running program

    always #5 clk = ~clk;

    washing_machine #(
        .FILL_CYCLES(FC), .WASH_CYCLES(WC), .RINSE_CYCLES(RC),
        .SPIN_CYCLES(SC), .DONE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .srt(srt),
        .fill(fill), .wash(wash), .rinse(rinse), .spin(spin), .done(done),
        .red(red), .green(green), .buzzer(buzzer)
    );

    // {fill, wash, rinse, spin, done, red, green, buzzer}
    function automatic logic [7:0] expv(input int p);
        logic [7:0] v;
        if (p <= 0 || p > TOTAL)      v = IDLE_V;
        else if (p <= FC)             v = 8'b1000_0100;
        else if (p <= FC + WC)        v = 8'b0100_0100;
        else if (p <= FC + WC + RC)   v = 8'b0010_0100;
        else if (p <= TOTAL - DC)     v = 8'b0001_0100;
        else                          v = {7'b0000_101, BZ};
        return v;
    endfunction

    function automatic logic [7:0] obs();
        return {fill, wash, rinse, spin, done, red, green, buzzer};
    endfunction

    task automatic tick(input logic s);
        @(negedge clk) srt = s;
        @(posedge clk);
        if (pos == 0)          pos = s ? 1 : 0;
        else if (pos == TOTAL) pos = 0;
        else                   pos = pos + 1;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b0; srt = 1'b0;
        repeat (2) @(posedge clk);
        #1 v = obs();
        total++;
        if (v !== IDLE_V) begin bad++; $display("FAIL reset_vals got=%b want=%b", v, IDLE_V); end
        @(negedge clk) rst = 1'b1;
        pos = 0;
        for (int c = 0; c < 50; c++) begin
            tick(1'b0);
            v = obs();
            total++;
            if (v !== IDLE_V) begin bad++; $display("FAIL idle_hold c=%0d got=%b want=%b", c, v, IDLE_V); end
        end
    endtask

    task automatic test_full_program();
        logic [7:0] v;
        int cnt[8];
        int first_green;
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        first_green = -1;
        for (int c = 1; c <= 135; c++) begin
            tick(c == 1);
            v = obs();
            total++;
            if (v !== expv(pos)) begin bad++; $display("FAIL full c=%0d got=%b want=%b", c, v, expv(pos)); end
            for (int b = 0; b < 8; b++) if (v[b]) cnt[b]++;
            if (v[1] && first_green < 0) first_green = c;
            if (c == 131) begin
                total++;
                if (v !== IDLE_V) begin bad++; $display("FAIL full_idle131 got=%b want=%b", v, IDLE_V); end
            end
        end
        total += 8;
        if (cnt[7] != FC) begin bad++; $display("FAIL fill_len got=%0d want=%0d", cnt[7], FC); end
        if (cnt[6] != WC) begin bad++; $display("FAIL wash_len got=%0d want=%0d", cnt[6], WC); end
        if (cnt[5] != RC) begin bad++; $display("FAIL rinse_len got=%0d want=%0d", cnt[5], RC); end
        if (cnt[4] != SC) begin bad++; $display("FAIL spin_len got=%0d want=%0d", cnt[4], SC); end
        if (cnt[3] != DC) begin bad++; $display("FAIL done_len got=%0d want=%0d", cnt[3], DC); end
        if (cnt[2] != TOTAL - DC) begin bad++; $display("FAIL red_len got=%0d want=%0d", cnt[2], TOTAL - DC); end
        if (cnt[0] != (BZ ? DC : 0)) begin bad++; $display("FAIL buzzer_len got=%0d want=%0d", cnt[0], BZ ? DC : 0); end
        if (first_green != TOTAL - DC + 1) begin bad++; $display("FAIL green_start got=%0d want=%0d", first_green, TOTAL - DC + 1); end
    endtask

    task automatic test_srt_ignored();
        logic [7:0] v;
        logic s;
        for (int c = 1; c <= 135; c++) begin
            s = (c == 1) || (c == 30) || (c == 100) ||
                (c > 1 && c <= 131 && $urandom_range(0, 3) == 0);
            tick(s);
            v = obs();
            total++;
            if (v !== expv(c)) begin bad++; $display("FAIL ignored c=%0d got=%b want=%b", c, v, expv(c)); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] v;
        for (int c = 1; c <= 45; c++) begin
            tick(c == 1);
            v = obs();
            total++;
            if (v !== expv(pos)) begin bad++; $display("FAIL pre_abort c=%0d got=%b want=%b", c, v, expv(pos)); end
        end
        #2 rst = 1'b0;
        #1 v = obs();
        pos = 0;
        total++;
        if (v !== IDLE_V) begin bad++; $display("FAIL abort_async got=%b want=%b", v, IDLE_V); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(1'b0);
            v = obs();
            total++;
            if (v !== IDLE_V) begin bad++; $display("FAIL post_abort c=%0d got=%b want=%b", c, v, IDLE_V); end
        end
        tick(1'b1);
        v = obs();
        total++;
        if (v !== expv(1)) begin bad++; $display("FAIL restart got=%b want=%b", v, expv(1)); end
        while (pos != 0) tick(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int c = 1; c <= 300; c++) begin
            tick(1'b1);
            v = obs();
            total++;
            if (v !== expv(pos)) begin bad++; $display("FAIL b2b c=%0d got=%b want=%b", c, v, expv(pos)); end
            if ($countones(v[7:3]) > 1 || v[2] === v[1]) begin
                total++; bad++;
                $display("FAIL b2b_excl c=%0d got=%b", c, v);
            end
            if (c == TOTAL + 1) begin
                total++;
                if (v !== IDLE_V) begin bad++; $display("FAIL b2b_gap got=%b want=%b", v, IDLE_V); end
            end
            if (c == TOTAL + 2) begin
                total++;
                if (v[7] !== 1'b1) begin bad++; $display("FAIL b2b_refill got=%b want=1", v[7]); end
            end
        end
        while (pos != 0) tick(1'b0);
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int c = 0; c < 500; c++) begin
            tick($urandom_range(0, 15) == 0);
            v = obs();
            total++;
            if (v !== expv(pos)) begin bad++; $display("FAIL rand c=%0d got=%b want=%b", c, v, expv(pos)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_srt_ignored();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
